// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M multiply/divide unit with stall/done/hold handshake; optional operand-reuse cache under MDU_REUSE_EN.
module mdu_iterative #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  input  logic             hold,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state;
  logic [2:0]         op_q;
  logic               neg_q, rneg_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] p_q, p_n, full;
  logic [CW-1:0]      cnt;
  logic               s1s, s2s, neg1, neg2, dz, ovf, special, hit;
  logic [WIDTH-1:0]   mag1, mag2, minv, spec_res, q, r, fix_lo, fix_hi, hit_res;
  logic [WIDTH:0]     sh, diff, sum;

  function automatic logic [WIDTH-1:0] sel(input logic [2:0] o, input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
    return o[2] ? (o[1] ? hi : lo) : (o[1:0] == 2'b00 ? lo : hi);
  endfunction

  assign minv     = {1'b1, {(WIDTH-1){1'b0}}};
  // MUL shares MULH signedness so both halves of one product are consistent
  assign s1s      = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign s2s      = s1s && (op != 3'b010);
  assign neg1     = s1s && src1[WIDTH-1];
  assign neg2     = s2s && src2[WIDTH-1];
  assign mag1     = neg1 ? -src1 : src1;
  assign mag2     = neg2 ? -src2 : src2;
  assign dz       = src2 == '0;
  assign ovf      = op[2] && !op[0] && src1 == minv && &src2;
  assign special  = op[2] && (dz || ovf);
  assign spec_res = dz ? (op[1] ? src1 : '1) : (op[1] ? '0 : minv);

  always_comb begin
    p_n  = p_q;
    sh   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        sh   = {p_n[2*WIDTH-1:WIDTH], p_n[WIDTH-1]};
        diff = sh - {1'b0, b_q};
        p_n  = {diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0], p_n[WIDTH-2:0], !diff[WIDTH]};
      end else begin
        sum = {1'b0, p_n[2*WIDTH-1:WIDTH]} + (p_n[0] ? {1'b0, b_q} : '0);
        p_n = {sum, p_n[WIDTH-1:1]};
      end
    end
  end

  assign full   = neg_q ? -p_q : p_q;
  assign q      = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign r      = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  assign fix_lo = op_q[2] ? q : full[WIDTH-1:0];
  assign fix_hi = op_q[2] ? r : full[2*WIDTH-1:WIDTH];

`ifdef MDU_REUSE_EN
  logic             c_valid;
  logic [2:0]       c_cls, cls;
  logic [WIDTH-1:0] c_s1, c_s2, c_lo, c_hi;
  assign cls     = op[2] ? {2'b10, op[0]} : (op[1] ? {2'b01, op[0]} : 3'b000);
  assign hit     = c_valid && c_s1 == src1 && c_s2 == src2 && c_cls == cls;
  assign hit_res = sel(op, c_lo, c_hi);
  always_ff @(posedge clk) begin
    if (rst || (flush && state != DONE))
      c_valid <= 1'b0;
    else if (state == IDLE && start && !hit) begin
      c_valid <= 1'b0;
      c_s1    <= src1;
      c_s2    <= src2;
      c_cls   <= cls;
    end else if (state == FIX) begin
      c_valid <= 1'b1;
      c_lo    <= fix_lo;
      c_hi    <= fix_hi;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
    end else if (flush && state != DONE)
      state <= IDLE;
    else
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          neg_q  <= neg1 ^ neg2;
          rneg_q <= neg1;
          b_q    <= mag2;
          p_q    <= {{WIDTH{1'b0}}, mag1};
          cnt    <= '0;
          if (special || hit) result <= special ? spec_res : hit_res;
          state  <= (special || hit) ? DONE : CALC;
        end
        CALC: begin
          p_q   <= p_n;
          cnt   <= cnt + CW'(UNROLL);
          state <= cnt == CW'(WIDTH - UNROLL) ? FIX : CALC;
        end
        FIX: begin
          result <= sel(op_q, fix_lo, fix_hi);
          state  <= DONE;
        end
        default: state <= hold ? DONE : IDLE;
      endcase
  end

  assign busy      = state == CALC || state == FIX;
  assign done      = state == DONE;
  assign stall_req = (state == IDLE && start && !flush) || busy;
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit for the EXE stage of the 5-stage RV32 pipeline; implements all eight RV32M operations.
- Takes forwarded `src1`/`src2` plus funct3.
- Raises `stall_req` to freeze IF/ID/EXE while iterating.
- Presents the result to the EXE/MEM register with a done/hold handshake that tolerates external pipeline stalls (memory wait).

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- UNROLL, 1, bits retired per CALC cycle; one of 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; valid M-type instruction in EXE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  WIDTH  rs1 operand (post-forwarding)
- src2  in  WIDTH  rs2 operand (post-forwarding)
- flush  in  1  branch/jump kill of the EXE instruction
- hold  in  1  downstream stall (cpu_stall); result must be held
- busy  out  1  state is CALC or FIX
- stall_req  out  1  freeze request to upstream stages
- done  out  1  result valid
- result  out  WIDTH  operation result

Behaviour:
- Reset and clocking: one clock, reset synchronous and active-high. On rst, state=IDLE, busy=0, done=0, stall_req=0, result=0, counter=0. Priority: rst > flush > start.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On the edge with start=1, latch op, operand magnitudes and result sign.
  - Signedness per op: MULHSU treats src1 signed, src2 unsigned.
  - Clear the accumulator, counter=0, go to CALC.
  - Special cases go straight to DONE instead:
    - Divide by zero (src2==0): DIV/DIVU result all ones; REM/REMU result src1.
    - Signed overflow (src1==min, src2==-1): DIV result min; REM result 0.
- CALC:
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring divide (shift remainder, trial subtract, set quotient bit).
  - UNROLL bits per cycle; counter advances by UNROLL each cycle.
  - After WIDTH/UNROLL cycles, go to FIX.
- FIX:
  - Negate product/quotient/remainder as required. Remainder takes the dividend's sign.
  - Select the low half for MUL, high half for MULH/MULHSU/MULHU.
  - Register result, go to DONE.
- DONE:
  - done=1, result stable.
  - If hold=1, stay in DONE. Otherwise go to IDLE on the next edge.
  - A start seen in DONE with hold=0 is a new instruction only after returning to IDLE; the EXE stage has advanced by then.
- Latency (UNROLL=1, normal op): done first high after WIDTH+2 edges following the accepting edge (34 for WIDTH=32). Special cases: done high after 1 edge.
- stall_req = (state==IDLE && start && !flush) || state==CALC || state==FIX. It is low in DONE so the pipeline captures result when hold=0.
- busy = state in {CALC, FIX}.
- flush:
  - At any edge outside DONE, forces IDLE with no done pulse.
  - In DONE, flush is ignored; the instruction has already committed.
- result: holds its last value in IDLE; only updated on FIX or on a special-case entry to DONE.
- Operand changes after acceptance are ignored; operands are latched.
- hold in IDLE/CALC/FIX has no effect; iteration continues.
- Widths: all intermediate sums are WIDTH+1 bits; the product register is 2*WIDTH bits; no truncation before FIX.

Optional Feature:
- Macro MDU_REUSE_EN.
- Defined:
  - Keep the last latched src1, src2 and signed-class, plus the valid quotient/remainder (or full 2*WIDTH product).
  - A start whose operands and class match takes IDLE -> DONE in one edge, returning the cached other half. Classes: DIV/REM pair, DIVU/REMU pair, same-signedness MUL pair.
  - The cache is cleared on rst, flush, and on any non-matching op.
- Undefined: every start iterates the full latency; no cache registers are present.

Test Plan:
- MUL, WIDTH=32: src1=7, src2=-3 -> done after 34 edges, result=0xFFFFFFEB; stall_req high for 33 cycles, low in DONE.
- MULH/MULHU/MULHSU: src1=0x80000000, src2=0xFFFFFFFF -> result 0x00000000 / 0x7FFFFFFF / 0x80000000 respectively.
- DIV/REM: src1=-7, src2=2 -> DIV -3 (0xFFFFFFFD), REM -1. Also DIVU 100/0 -> 0xFFFFFFFF after 1 edge; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- hold and flush:
  - hold=1 for 5 cycles entering DONE -> done and result stay constant for 5 cycles, then IDLE.
  - flush at CALC cycle 10 -> IDLE next edge, no done, stall_req drops.
- rst asserted mid-CALC -> next edge all outputs 0, state IDLE. A subsequent DIVU 100/7 -> 14 after 34 edges.
- MDU_REUSE_EN:
  - DIV 100/7 then REM 100/7 -> second done after 1 edge, result 2.
  - DIV 100/7 then REM 100/8 -> full 34-edge latency, result 4.
